// File: rtl/fetch_stall_ctrl.sv
// rtl/fetch_stall_ctrl.sv - fetch-side PC, IF/ID and ID/EX-control registers with stall/flush/bubble handling
//
// Purpose:
//   Owns the program counter, the IF/ID pipeline register and the control half
//   of the ID/EX register for a 5-stage MIPS pipeline. Responds to the hazard
//   unit's PCWrite/IFIDWrite, flushes the wrong-path fetch on a taken branch and
//   injects a control bubble into EX whenever ID is held or empty.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, adds saturating StallCount and FlushCount output ports.
//
// Ports:
//   clk           in   pipeline clock, rising edge
//   rst           in   synchronous active-high reset (priority over everything)
//   PCWrite       in   1 = PC may update, 0 = hold PC
//   IFIDWrite     in   1 = IF/ID may update, 0 = hold IF/ID and bubble ID/EX
//   BranchTaken   in   branch/jump resolved taken in ID this cycle
//   BranchTarget  in   redirect address, bits [1:0] ignored
//   IMemData      in   instruction at IMemAddr (combinational memory)
//   IDCtrl        in   control bundle decoded from IFIDInstr
//   IMemAddr      out  current PC (register)
//   IFIDInstr     out  registered instruction
//   IFIDPCPlus4   out  registered PC+4 of that instruction
//   IFIDValid     out  IF/ID holds a real instruction
//   IDEXCtrl      out  registered control bundle for EX
//   IDEXValid     out  ID/EX holds a real instruction
//   StallCount    out  (FETCH_PERF_CNT_EN) edges with PCWrite=0, saturating
//   FlushCount    out  (FETCH_PERF_CNT_EN) IF/ID flushes, saturating

module fetch_stall_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CTRL_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCWrite,
    input  logic              IFIDWrite,
    input  logic              BranchTaken,
    input  logic [31:0]       BranchTarget,
    input  logic [31:0]       IMemData,
    input  logic [CTRL_W-1:0] IDCtrl,
    output logic [31:0]       IMemAddr,
    output logic [31:0]       IFIDInstr,
    output logic [31:0]       IFIDPCPlus4,
    output logic              IFIDValid,
    output logic [CTRL_W-1:0] IDEXCtrl,
    output logic              IDEXValid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       StallCount,
    output logic [31:0]       FlushCount
`endif
);

    logic [31:0] pc_plus4;
    logic        flush;
    logic        redirect;

    // Word-aligned fetch: the low target bits are dropped on redirect.
    logic unused_target_bits;
    assign unused_target_bits = ^BranchTarget[1:0];

    // Natural 32-bit overflow gives the required wrap from FFFF_FFFC to 0.
    assign pc_plus4 = IMemAddr + 32'd4;

    // A branch only redirects when the PC is allowed to move; a stalled
    // branch is re-resolved by ID after the stall clears.
    assign redirect = PCWrite & BranchTaken;

    // The wrong-path fetch is discarded only if IF/ID is actually being
    // written this cycle and the redirect takes effect.
    assign flush = IFIDWrite & redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            IMemAddr    <= RESET_PC;
            IFIDInstr   <= 32'd0;
            IFIDPCPlus4 <= 32'd0;
            IFIDValid   <= 1'b0;
            IDEXCtrl    <= '0;
            IDEXValid   <= 1'b0;
        end else begin
            // PC
            if (PCWrite) begin
                if (BranchTaken) begin
                    IMemAddr <= {BranchTarget[31:2], 2'b00};
                end else begin
                    IMemAddr <= pc_plus4;
                end
            end

            // IF/ID: PCWrite=0 with IFIDWrite=1 legitimately refetches the
            // same PC, so the load path does not look at PCWrite.
            if (IFIDWrite) begin
                if (flush) begin
                    IFIDInstr   <= 32'd0;
                    IFIDPCPlus4 <= 32'd0;
                    IFIDValid   <= 1'b0;
                end else begin
                    IFIDInstr   <= IMemData;
                    IFIDPCPlus4 <= pc_plus4;
                    IFIDValid   <= 1'b1;
                end
            end

            // ID/EX control: a held ID stage must not issue twice, and an
            // empty IF/ID slot has nothing to issue. The branch sitting in
            // IF/ID during a flush still advances here.
            if (!IFIDWrite || !IFIDValid) begin
                IDEXCtrl  <= '0;
                IDEXValid <= 1'b0;
            end else begin
                IDEXCtrl  <= IDCtrl;
                IDEXValid <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCount <= 32'd0;
            FlushCount <= 32'd0;
        end else begin
            if (!PCWrite && (StallCount != 32'hFFFF_FFFF)) begin
                StallCount <= StallCount + 32'd1;
            end
            if (flush && (FlushCount != 32'hFFFF_FFFF)) begin
                FlushCount <= FlushCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/fetch_stall_ctrl.md
# fetch_stall_ctrl

Fetch-side responder to the load-use hazard handshake. Owns the PC register, the IF/ID pipeline register, and the control half of the ID/EX register. It honours PCWrite/IFIDWrite from the hazard detection unit, flushes on taken branches, and injects a control bubble into EX whenever ID is held. It sits between instruction memory, the decode stage and the EX stage of the 5-stage MIPS pipeline.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
- CTRL_W, 9, width of the decoded control bundle carried into ID/EX
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- PCWrite  in  1  1 = PC may update; 0 = hold PC (stall)
- IFIDWrite  in  1  1 = IF/ID may update; 0 = hold IF/ID and bubble ID/EX
- BranchTaken  in  1  branch/jump resolved taken in ID this cycle
- BranchTarget  in  32  target address; bits [1:0] ignored
- IMemData  in  32  instruction read at IMemAddr (combinational memory)
- IDCtrl  in  CTRL_W  control bundle decoded from IFIDInstr
- IMemAddr  out  32  current PC (register output)
- IFIDInstr  out  32  registered instruction
- IFIDPCPlus4  out  32  registered PC+4 of that instruction
- IFIDValid  out  1  IF/ID holds a real instruction
- IDEXCtrl  out  CTRL_W  registered control bundle for EX
- IDEXValid  out  1  ID/EX holds a real instruction

## Operation
- Reset (rst=1 at edge): PC=RESET_PC; IFIDInstr=0, IFIDPCPlus4=0, IFIDValid=0; IDEXCtrl=0, IDEXValid=0; counters 0. Reset has priority over all other inputs, including mid-stall and mid-flush.
- PC update, priority order:
  - PCWrite=0: PC holds. Any BranchTaken in the same cycle is ignored; ID re-resolves the branch after the stall.
  - PCWrite=1 and BranchTaken=1: PC <= {BranchTarget[31:2],2'b00}.
  - Otherwise: PC <= PC+4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
- IF/ID update:
  - IFIDWrite=0: all IF/ID fields hold.
  - IFIDWrite=1 and BranchTaken=1 and PCWrite=1: flush. IFIDInstr=0 (nop), IFIDPCPlus4=0, IFIDValid=0.
  - Otherwise: IFIDInstr <= IMemData, IFIDPCPlus4 <= PC+4, IFIDValid <= 1.
- ID/EX control:
  - IFIDWrite=0 or IFIDValid=0: bubble, IDEXCtrl <= 0, IDEXValid <= 0.
  - Otherwise: IDEXCtrl <= IDCtrl, IDEXValid <= 1.
  - The branch instruction itself proceeds to EX; only the wrong-path fetch is flushed.
- PCWrite and IFIDWrite are honoured independently. PCWrite=0 with IFIDWrite=1 reloads IF/ID from the unchanged PC, which is legal.

## Timing
- IMemAddr is a register output with zero combinational path from inputs.
- Fetch latency: the instruction at PC appears on IFIDInstr 1 edge later. Its control appears on IDEXCtrl 2 edges after fetch when there are no stalls.
- Load-use stall: a single stall cycle (PCWrite=IFIDWrite=0) holds PC and IF/ID for exactly 1 edge and produces exactly one IDEXValid=0 cycle.
- Taken branch: one flush bubble. The target instruction reaches IF/ID on the edge after the redirect.
- First valid IFIDValid=1 occurs on the 1st edge after rst deasserts. First IDEXValid=1 occurs on the 2nd edge.

## Configuration
- FETCH_PERF_CNT_EN defined: adds two output ports, StallCount out 32 and FlushCount out 32, both reset to 0.
  - StallCount increments on each non-reset edge with PCWrite=0.
  - FlushCount increments on each flush as defined above.
  - Both saturate at 32'hFFFF_FFFF.
- FETCH_PERF_CNT_EN undefined: neither port nor any counter logic exists, and all other behaviour is identical.

## Test plan
- Reset with RESET_PC=32'h0000_0040, rst held 2 cycles, then released with PCWrite=IFIDWrite=1 -> IMemAddr 0x40, 0x44, 0x48 on consecutive cycles; IFIDValid=1 after the 1st edge; IDEXValid=1 after the 2nd edge.
- Load-use stall: drive PCWrite=IFIDWrite=0 for 1 cycle at PC=0x48 -> IMemAddr stays 0x48; IFIDInstr unchanged; IDEXCtrl=0 and IDEXValid=0 for one cycle; fetch resumes at 0x4C.
- Taken branch with BranchTarget=32'h0000_0103 at PC=0x50 -> PC=0x100; IFIDInstr=0 with IFIDValid=0 for one cycle; branch ctrl still reaches IDEXCtrl.
- Stall and branch in the same cycle (PCWrite=IFIDWrite=0, BranchTaken=1) -> no redirect and no flush. Reasserting the branch with PCWrite=1 next cycle redirects.
- PC wrap: force PC to 32'hFFFF_FFFC -> next IMemAddr=0; reset asserted during a stall -> all outputs return to reset values at the next edge.
- With FETCH_PERF_CNT_EN: 3 stalls and 2 flushes -> StallCount=3, FlushCount=2; a preloaded saturated counter stays 32'hFFFF_FFFF.
